// File: rtl/demux_scan_if.sv
// Control/data bundle for demux_scan: the driver side uses master, the router uses slave.
interface demux_scan_if #(
   parameter int N_CH    = 32,
   parameter int SEL_W   = 5,
   parameter int DWELL_W = 16
);
   logic               data_in;
   logic [SEL_W-1:0]   sel;
   logic               sel_load;
   logic [1:0]         mode;
   logic [DWELL_W-1:0] dwell;
   logic               start;
   logic               stop;
   logic [N_CH-1:0]    data_out;
   logic [SEL_W-1:0]   cur_ch;
   logic               busy;
   logic               wrap;
   logic               sel_err;

   modport master (
      output data_in, sel, sel_load, mode, dwell, start, stop,
      input  data_out, cur_ch, busy, wrap, sel_err
   );

   modport slave (
      input  data_in, sel, sel_load, mode, dwell, start, stop,
      output data_out, cur_ch, busy, wrap, sel_err
   );
endinterface

// File: rtl/demux_scan.sv
// Serial 1-to-N_CH demultiplexer with manual hold, timed scan and single-pulse modes.
module demux_scan #(
   parameter int N_CH    = 32,
   parameter int SEL_W   = 5,
   parameter int DWELL_W = 16
) (
   input  logic          clk,
   input  logic          rst,
   demux_scan_if.slave   bus
);
   typedef enum logic [1:0] {S_IDLE, S_HOLD, S_SCAN, S_PULSE} state_t;

   state_t             r_state, w_state_next;
   logic [SEL_W-1:0]   r_cur_ch, w_cur_ch_next;
   logic [DWELL_W-1:0] r_cnt, w_cnt_next;
   logic [DWELL_W-1:0] r_dwell, w_dwell_next;
   logic               r_wrap, w_wrap_next;
   logic               r_sel_err, w_sel_err_next;
   logic [N_CH-1:0]    r_data_out, w_data_out_next;
   logic [N_CH-1:0]    w_route;
   logic [DWELL_W-1:0] w_dwell_latch;
   logic               w_sel_ok;
   logic               w_last;
   logic               w_cur_max;

   // One extra bit so N_CH itself is representable when N_CH is a power of two.
   assign w_sel_ok      = {1'b0, bus.sel} < (SEL_W+1)'(N_CH);
   assign w_last        = (r_cnt == r_dwell - DWELL_W'(1));
   assign w_cur_max     = (r_cur_ch == SEL_W'(N_CH - 1));
   assign w_dwell_latch = (bus.dwell == '0) ? DWELL_W'(1) : bus.dwell;

   generate
      for (genvar gi = 0; gi < N_CH; gi++) begin : g_route
         assign w_route[gi] = bus.data_in && (r_cur_ch == SEL_W'(gi));
      end
   endgenerate

   always_comb begin
      w_state_next    = r_state;
      w_cur_ch_next   = r_cur_ch;
      w_cnt_next      = r_cnt;
      w_dwell_next    = r_dwell;
      w_wrap_next     = 1'b0;
      w_sel_err_next  = 1'b0;
      w_data_out_next = '0;

      // Loading before the mode dispatch lets a simultaneous start route the new channel.
      if ((r_state == S_IDLE || r_state == S_HOLD) && bus.sel_load) begin
         if (w_sel_ok) w_cur_ch_next  = bus.sel;
         else          w_sel_err_next = 1'b1;
      end

      if (bus.stop) begin
         w_state_next = S_IDLE;
      end else begin
         if (r_state != S_IDLE) w_data_out_next = w_route;
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  case (bus.mode)
                     2'b00: w_state_next = S_HOLD;
                     2'b01: begin
                        w_state_next = S_SCAN;
                        w_cnt_next   = '0;
                        w_dwell_next = w_dwell_latch;
                     end
                     2'b10: begin
                        w_state_next = S_PULSE;
                        w_cnt_next   = '0;
                        w_dwell_next = w_dwell_latch;
                     end
                     default: w_state_next = S_IDLE;
                  endcase
               end
            end
            S_HOLD: w_state_next = S_HOLD;
            S_SCAN: begin
               if (w_last) begin
                  w_cnt_next = '0;
                  if (w_cur_max) begin
                     w_cur_ch_next = '0;
                     w_wrap_next   = 1'b1;
                  end else begin
                     w_cur_ch_next = r_cur_ch + SEL_W'(1);
                  end
               end else begin
                  w_cnt_next = r_cnt + DWELL_W'(1);
               end
            end
            S_PULSE: begin
               if (w_last) begin
                  w_state_next = S_IDLE;
                  w_cnt_next   = '0;
               end else begin
                  w_cnt_next = r_cnt + DWELL_W'(1);
               end
            end
            default: w_state_next = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_cur_ch   <= '0;
         r_cnt      <= '0;
         r_dwell    <= DWELL_W'(1);
         r_wrap     <= 1'b0;
         r_sel_err  <= 1'b0;
         r_data_out <= '0;
      end else begin
         r_state    <= w_state_next;
         r_cur_ch   <= w_cur_ch_next;
         r_cnt      <= w_cnt_next;
         r_dwell    <= w_dwell_next;
         r_wrap     <= w_wrap_next;
         r_sel_err  <= w_sel_err_next;
         r_data_out <= w_data_out_next;
      end
   end

   assign bus.data_out = r_data_out;
   assign bus.cur_ch   = r_cur_ch;
   assign bus.busy     = (r_state != S_IDLE);
   assign bus.wrap     = r_wrap;
   assign bus.sel_err  = r_sel_err;
endmodule

// File: tb/tb_demux_scan.sv
// Directed scoreboard bench for demux_scan at N_CH = 32, 4 and 20.
module tb_demux_scan;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   demux_scan_if #(.N_CH(32), .SEL_W(5), .DWELL_W(16)) if0 ();
   demux_scan_if #(.N_CH(4),  .SEL_W(2), .DWELL_W(16)) if1 ();
   demux_scan_if #(.N_CH(20), .SEL_W(5), .DWELL_W(16)) if2 ();

   demux_scan #(.N_CH(32), .SEL_W(5), .DWELL_W(16)) u0 (.clk(clk), .rst(rst), .bus(if0.slave));
   demux_scan #(.N_CH(4),  .SEL_W(2), .DWELL_W(16)) u1 (.clk(clk), .rst(rst), .bus(if1.slave));
   demux_scan #(.N_CH(20), .SEL_W(5), .DWELL_W(16)) u2 (.clk(clk), .rst(rst), .bus(if2.slave));

   typedef struct packed {
      logic [1:0]  inst;
      logic [31:0] dout;
      logic [7:0]  cur;
      logic        busy;
      logic        wrap;
      logic        serr;
   } exp_t;

   exp_t  sb[$];
   string sb_tag[$];
   int    n_cmp = 0;
   int    n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      if (obs !== expv) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic expect_out(input int inst, input string tag, input logic [31:0] d,
                             input int c, input logic b, input logic w, input logic s);
      exp_t e;
      e.inst = 2'(inst);
      e.dout = d;
      e.cur  = 8'(c);
      e.busy = b;
      e.wrap = w;
      e.serr = s;
      sb.push_back(e);
      sb_tag.push_back(tag);
   endtask

   task automatic sample(input logic [1:0] inst, output logic [31:0] d, output logic [7:0] c,
                         output logic b, output logic w, output logic s);
      case (inst)
         2'd0: begin d = if0.data_out;      c = 8'(if0.cur_ch); b = if0.busy; w = if0.wrap; s = if0.sel_err; end
         2'd1: begin d = 32'(if1.data_out); c = 8'(if1.cur_ch); b = if1.busy; w = if1.wrap; s = if1.sel_err; end
         default: begin d = 32'(if2.data_out); c = 8'(if2.cur_ch); b = if2.busy; w = if2.wrap; s = if2.sel_err; end
      endcase
   endtask

   task automatic clear_strobes();
      if0.sel_load = 1'b0; if0.start = 1'b0; if0.stop = 1'b0;
      if1.sel_load = 1'b0; if1.start = 1'b0; if1.stop = 1'b0;
      if2.sel_load = 1'b0; if2.start = 1'b0; if2.stop = 1'b0;
   endtask

   task automatic tick();
      exp_t        e;
      string       t;
      logic [31:0] d;
      logic [7:0]  c;
      logic        b, w, s;
      @(posedge clk);
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         t = sb_tag.pop_front();
         sample(e.inst, d, c, b, w, s);
         $display("tx inst=%0d %s cur=%0d dout=%08h busy=%0b wrap=%0b serr=%0b",
                  e.inst, t, c, d, b, w, s);
         chk({t, ".cur"},  32'(c), 32'(e.cur));
         chk({t, ".dout"}, d,      e.dout);
         chk({t, ".busy"}, 32'(b), 32'(e.busy));
         chk({t, ".wrap"}, 32'(w), 32'(e.wrap));
         chk({t, ".serr"}, 32'(s), 32'(e.serr));
      end
      clear_strobes();
   endtask

   initial begin
      logic [31:0] d;
      rst = 1'b1;
      if0.data_in = 1'b0; if0.sel = '0; if0.mode = 2'b00; if0.dwell = '0;
      if1.data_in = 1'b0; if1.sel = '0; if1.mode = 2'b00; if1.dwell = '0;
      if2.data_in = 1'b0; if2.sel = '0; if2.mode = 2'b00; if2.dwell = '0;
      clear_strobes();
      repeat (3) @(posedge clk);
      #1;
      chk("rst.dout", if0.data_out, 32'h0);
      chk("rst.cur",  32'(if0.cur_ch), 32'h0);
      chk("rst.busy", 32'(if0.busy), 32'h0);
      chk("rst.wrap", 32'(if1.wrap), 32'h0);
      chk("rst.serr", 32'(if2.sel_err), 32'h0);
      rst = 1'b0;

      // Manual hold: start on the first edge after reset release.
      if0.sel = 5'd0; if0.sel_load = 1'b1; if0.mode = 2'b00; if0.start = 1'b1; if0.data_in = 1'b1;
      expect_out(0, "man.start", 32'h0, 0, 1, 0, 0); tick();
      expect_out(0, "man.ch0", 32'h1, 0, 1, 0, 0); tick();
      if0.sel = 5'd31; if0.sel_load = 1'b1;
      expect_out(0, "man.load31", 32'h1, 31, 1, 0, 0); tick();
      expect_out(0, "man.ch31", 32'h8000_0000, 31, 1, 0, 0); tick();
      if0.data_in = 1'b0;
      expect_out(0, "man.din0", 32'h0, 31, 1, 0, 0); tick();
      if0.data_in = 1'b1; if0.stop = 1'b1;
      expect_out(0, "man.stop", 32'h0, 31, 0, 0, 0); tick();
      expect_out(0, "man.idle", 32'h0, 31, 0, 0, 0); tick();

      // Conflicts.
      if0.start = 1'b1; if0.stop = 1'b1; if0.mode = 2'b00;
      expect_out(0, "cf.startstop", 32'h0, 31, 0, 0, 0); tick();
      if0.start = 1'b1; if0.mode = 2'b11;
      expect_out(0, "cf.mode11", 32'h0, 31, 0, 0, 0); tick();
      if0.sel = 5'd3; if0.sel_load = 1'b1; if0.start = 1'b1; if0.mode = 2'b01; if0.dwell = 16'd3;
      expect_out(0, "cf.loadstart", 32'h0, 3, 1, 0, 0); tick();
      if0.mode = 2'b10; if0.dwell = 16'd1;
      expect_out(0, "cf.first", 32'h8, 3, 1, 0, 0); tick();
      if0.start = 1'b1; if0.mode = 2'b00; if0.sel_load = 1'b1; if0.sel = 5'd9;
      expect_out(0, "cf.ignored", 32'h8, 3, 1, 0, 0); tick();
      expect_out(0, "cf.adv", 32'h8, 4, 1, 0, 0); tick();
      expect_out(0, "cf.ch4", 32'h10, 4, 1, 0, 0); tick();
      if0.stop = 1'b1;
      expect_out(0, "cf.stop", 32'h0, 4, 0, 0, 0); tick();

      // Pulse of five cycles on channel 7.
      if0.sel = 5'd7; if0.sel_load = 1'b1;
      expect_out(0, "pl.load", 32'h0, 7, 0, 0, 0); tick();
      if0.start = 1'b1; if0.mode = 2'b10; if0.dwell = 16'd5;
      expect_out(0, "pl.start", 32'h0, 7, 1, 0, 0); tick();
      if0.mode = 2'b01; if0.dwell = 16'd1;
      for (int i = 0; i < 4; i++) begin
         expect_out(0, "pl.on", 32'h80, 7, 1, 0, 0); tick();
      end
      expect_out(0, "pl.last", 32'h80, 7, 0, 0, 0); tick();
      expect_out(0, "pl.done", 32'h0, 7, 0, 0, 0); tick();

      // Scan wrap at N_CH=4, dwell=2.
      if1.data_in = 1'b1; if1.mode = 2'b01; if1.dwell = 16'd2; if1.start = 1'b1;
      for (int i = 0; i < 10; i++) begin
         d = 32'd1;
         d = (i == 0) ? 32'h0 : (d << (((i - 1) / 2) % 4));
         expect_out(1, "sc.step", d, (i / 2) % 4, 1, (i == 8), 0); tick();
      end
      if1.stop = 1'b1;
      expect_out(1, "sc.stop", 32'h0, 0, 0, 0, 0); tick();

      // Bad select and zero dwell at N_CH=20.
      if2.data_in = 1'b1;
      if2.sel = 5'd6;  if2.sel_load = 1'b1;
      expect_out(2, "bs.load6", 32'h0, 6, 0, 0, 0); tick();
      if2.sel = 5'd25; if2.sel_load = 1'b1;
      expect_out(2, "bs.sel25", 32'h0, 6, 0, 0, 1); tick();
      expect_out(2, "bs.clear", 32'h0, 6, 0, 0, 0); tick();
      if2.sel = 5'd20; if2.sel_load = 1'b1;
      expect_out(2, "bs.sel20", 32'h0, 6, 0, 0, 1); tick();
      if2.sel = 5'd19; if2.sel_load = 1'b1;
      expect_out(2, "bs.sel19", 32'h0, 19, 0, 0, 0); tick();
      if2.start = 1'b1; if2.mode = 2'b01; if2.dwell = 16'd0;
      expect_out(2, "bs.start", 32'h0, 19, 1, 0, 0); tick();
      expect_out(2, "bs.d0a", 32'h8_0000, 0, 1, 1, 0); tick();
      expect_out(2, "bs.d0b", 32'h1, 1, 1, 0, 0); tick();
      expect_out(2, "bs.d0c", 32'h2, 2, 1, 0, 0); tick();
      if2.stop = 1'b1;
      expect_out(2, "bs.stop", 32'h0, 2, 0, 0, 0); tick();

      // Asynchronous reset mid-scan, just before a wrap would occur.
      if1.mode = 2'b01; if1.dwell = 16'd1; if1.start = 1'b1;
      expect_out(1, "ar.start", 32'h0, 0, 1, 0, 0); tick();
      expect_out(1, "ar.s1", 32'h1, 1, 1, 0, 0); tick();
      expect_out(1, "ar.s2", 32'h2, 2, 1, 0, 0); tick();
      expect_out(1, "ar.s3", 32'h4, 3, 1, 0, 0); tick();
      #2;
      rst = 1'b1;
      #1;
      chk("ar.dout", 32'(if1.data_out), 32'h0);
      chk("ar.cur",  32'(if1.cur_ch), 32'h0);
      chk("ar.busy", 32'(if1.busy), 32'h0);
      chk("ar.wrap", 32'(if1.wrap), 32'h0);
      @(posedge clk);
      #1;
      chk("ar.wrap_hold", 32'(if1.wrap), 32'h0);
      chk("ar.cur_hold",  32'(if1.cur_ch), 32'h0);
      rst = 1'b0;
      if1.mode = 2'b00; if1.start = 1'b1;
      expect_out(1, "ar.restart", 32'h0, 0, 1, 0, 0); tick();
      expect_out(1, "ar.hold", 32'h1, 0, 1, 0, 0); tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
